// File: rtl/writeback_buffer_pkg.sv
// writeback_buffer_pkg: shared state encoding and buffer entry layout for the write-back buffer.
package writeback_buffer_pkg;
  localparam int WBB_ADDR_W = 16;
  localparam int WBB_LINE_W = 1024;
  typedef enum logic [1:0] {IDLE, RESP, RD_MISS, DRAIN} state_t;
  typedef struct packed {
    logic                  valid;
    logic [WBB_ADDR_W-1:0] addr;
    logic [WBB_LINE_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wbb_match.sv
// wbb_match: parallel address comparator over all buffer entries.
module wbb_match #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit,
  output logic [DEPTH-1:0]             onehot,
  output logic [IW-1:0]                idx
);
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = valid[i] && addr[i] == key;
      if (onehot[i]) idx = IW'(i);
    end
  end
  assign hit = |onehot;
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: FIFO write-back buffer between L2 and memory; read misses bypass pending drains,
// buffered lines answer read hits and absorb repeated evictions in place.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = WBB_ADDR_W,
  parameter int LINE_W = WBB_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_read,
  input  logic              ev_write,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic [LINE_W-1:0] ev_wdata,
  output logic [LINE_W-1:0] ev_rdata,
  output logic              ev_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int PW = $clog2(DEPTH);
  state_t state_q, state_d;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic hit, full, go_drain;
  logic [DEPTH-1:0] hit_oh;
  logic [PW-1:0] hit_idx;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ent_q[i].valid;
      ent_addr[i] = ent_q[i].addr;
    end
  end
  wbb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match (
    .valid(ent_valid),
    .addr(ent_addr),
    .key(ev_addr),
    .hit(hit),
    .onehot(hit_oh),
    .idx(hit_idx)
  );
  assign full = count_q == (PW+1)'(DEPTH);
  always_comb begin
    state_d = state_q;
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    paddr_d = paddr_q;
    go_drain = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_write && hit) begin
          for (int i = 0; i < DEPTH; i++) if (hit_oh[i]) ent_d[i].data = ev_wdata;
          state_d = RESP;
        end else if (ev_write && !full) begin
          ent_d[tail_q] = '{valid: 1'b1, addr: ev_addr, data: ev_wdata};
          tail_d = tail_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = RESP;
        end else if (ev_write) begin
          go_drain = 1'b1;
        end else if (ev_read && hit) begin
          rdata_d = ent_q[hit_idx].data;
          state_d = RESP;
        end else if (ev_read) begin
          paddr_d = ev_addr;
          state_d = RD_MISS;
        end else begin
          go_drain = count_q != '0;
        end
      end
      RD_MISS: begin
        rdata_d = pmem_resp ? pmem_rdata : rdata_q;
        state_d = pmem_resp ? RESP : RD_MISS;
      end
      DRAIN: begin
        // head stays hittable until memory has accepted it
        if (pmem_resp) begin
          ent_d[head_q].valid = 1'b0;
          head_d = head_q + 1'b1;
          count_d = count_q - 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_drain) begin
      paddr_d = ent_q[head_q].addr;
      wdata_d = ent_q[head_q].data;
      state_d = DRAIN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      paddr_q <= paddr_d;
    end
  end
  assign ev_resp = state_q == RESP;
  assign pmem_read = state_q == RD_MISS;
  assign pmem_write = state_q == DRAIN;
  assign pmem_addr = paddr_q;
  assign pmem_wdata = wdata_q;
  assign ev_rdata = rdata_q;
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: randomized and directed scoreboard bench; the model is a FIFO of buffered lines
// plus a memory image, and every drain and read response is compared against it.
module tb_writeback_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int LW = 1024;

  logic clk, rst_n, ev_read, ev_write, ev_resp, pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] ev_addr, pmem_addr;
  logic [LW-1:0] ev_wdata, ev_rdata, pmem_wdata, pmem_rdata;

  writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_read(ev_read), .ev_write(ev_write), .ev_addr(ev_addr), .ev_wdata(ev_wdata),
    .ev_rdata(ev_rdata), .ev_resp(ev_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {bit is_rd; logic [AW-1:0] addr; logic [LW-1:0] data;} item_t;
  typedef struct {logic [AW-1:0] addr; logic [LW-1:0] data;} line_t;

  int n_chk = 0, n_pass = 0;
  item_t sb[$];
  line_t buf_m[$];
  logic [LW-1:0] mem [logic [AW-1:0]];
  bit hold = 0;
  int dmax = 0;
  int rd_cnt = 0, wr_cnt = 0;
  bit op_log[$];
  item_t mon_it;
  int mon_k;

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
  endtask

  function automatic logic [LW-1:0] init_val(logic [AW-1:0] a);
    return {64{a}};
  endfunction

  function automatic logic [LW-1:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic int find(logic [AW-1:0] a);
    foreach (buf_m[i]) if (buf_m[i].addr == a) return i;
    return -1;
  endfunction

  function automatic logic [LW-1:0] expect_rd(logic [AW-1:0] a);
    int k = find(a);
    return k >= 0 ? buf_m[k].data : mem_rd(a);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: each ev_resp retires the oldest outstanding request against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && ev_resp) begin
      if (sb.size() == 0) chk("resp_unexpected", ev_resp, 0);
      else begin
        mon_it = sb.pop_front();
        if (mon_it.is_rd) chk("rdata", ev_rdata, expect_rd(mon_it.addr));
        else begin
          mon_k = find(mon_it.addr);
          if (mon_k >= 0) buf_m[mon_k].data = mon_it.data;
          else buf_m.push_back('{addr: mon_it.addr, data: mon_it.data});
        end
      end
    end
  end

  // Memory responder: random latency, optional hold-off; drains are checked against the model FIFO head.
  initial begin
    int w = -1;
    pmem_resp = 0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 0;
      if (!rst_n) w = -1;
      else if (pmem_read || pmem_write) begin
        chk("strobe_excl", pmem_read & pmem_write, 0);
        if (w < 0) w = int'($urandom_range(dmax, 0));
        if (!hold) begin
          if (w == 0) begin
            pmem_resp = 1;
            if (pmem_read) begin
              pmem_rdata = mem_rd(pmem_addr);
              rd_cnt++;
              op_log.push_back(1'b1);
            end else begin
              if (buf_m.size() == 0) chk("drain_unexpected", pmem_write, 0);
              else begin
                chk("drain_addr", pmem_addr, buf_m[0].addr);
                chk("drain_data", pmem_wdata, buf_m[0].data);
                buf_m.delete(0);
              end
              mem[pmem_addr] = pmem_wdata;
              wr_cnt++;
              op_log.push_back(1'b0);
            end
            w = -1;
          end else w--;
        end
      end else w = -1;
    end
  end

  task automatic req(input bit rd, input logic [AW-1:0] a, input logic [LW-1:0] d, output int lat);
    item_t it;
    it.is_rd = rd;
    it.addr = a;
    it.data = d;
    sb.push_back(it);
    ev_read = rd;
    ev_write = !rd;
    ev_addr = a;
    ev_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ev_resp && lat < 3000);
    if (!ev_resp) chk("req_timeout", ev_resp, 1);
    ev_read = 0;
    ev_write = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((buf_m.size() != 0 || pmem_write || pmem_read) && n < 3000);
    chk("drain_settle", buf_m.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, r0, w0, mark;
    logic [LW-1:0] a_dat, b_dat;
    rst_n = 0;
    ev_read = 0;
    ev_write = 0;
    ev_addr = '0;
    ev_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ev_resp", ev_resp, 0);
    chk("rst_ev_rdata", ev_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_addr, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    rst_n = 1;
    @(negedge clk);

    // reset while a drain is stalled in memory
    hold = 1;
    req(0, 16'h0010, rand_line(), lat);
    for (int i = 0; i < 10 && !pmem_write; i++) @(negedge clk);
    chk("pre_rst_drain", pmem_write, 1);
    #2 rst_n = 0;
    #1 chk("rst_drops_write", pmem_write, 0);
    chk("rst_drops_addr", pmem_addr, 0);
    buf_m.delete();
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    r0 = rd_cnt;
    req(1, 16'h0010, '0, lat);
    chk("rst_read_misses", rd_cnt - r0, 1);
    @(negedge clk);

    // single write then drain
    w0 = wr_cnt;
    a_dat = rand_line();
    req(0, 16'h0010, a_dat, lat);
    chk("wr_lat", lat, 1);
    wait_idle();
    chk("wr_drain_cnt", wr_cnt - w0, 1);
    chk("wr_drain_mem", mem_rd(16'h0010), a_dat);

    // read hit served from the buffer
    req(0, 16'h0020, rand_line(), lat);
    r0 = rd_cnt;
    req(1, 16'h0020, '0, lat);
    chk("hit_lat", lat, 2);
    chk("hit_no_pmem", rd_cnt - r0, 0);
    wait_idle();

    // coalescing write
    w0 = wr_cnt;
    b_dat = rand_line();
    req(0, 16'h0030, rand_line(), lat);
    req(0, 16'h0030, b_dat, lat);
    chk("coalesce_lat", lat, 2);
    wait_idle();
    chk("coalesce_drains", wr_cnt - w0, 1);
    chk("coalesce_mem", mem_rd(16'h0030), b_dat);

    // fill, then a further write stalls behind one FIFO-order drain
    hold = 1;
    for (int i = 0; i < DEPTH; i++) begin
      req(0, 16'h0040 + 16'(i * 16), rand_line(), lat);
      chk("fill_lat", lat, i == 0 ? 1 : 2);
    end
    fork
      req(0, 16'h0080, rand_line(), lat);
      begin
        repeat (20) @(negedge clk);
        chk("stall_draining", pmem_write, 1);
        chk("stall_head_addr", pmem_addr, 16'h0040);
        chk("stall_no_resp", ev_resp, 0);
        hold = 0;
      end
    join
    chk("stall_lat_long", lat > 20, 1);
    hold = 1;
    req(0, 16'h0050, rand_line(), lat);
    chk("full_coalesce_lat", lat, 2);
    hold = 0;
    wait_idle();

    // read miss overtakes pending drains
    w0 = wr_cnt;
    r0 = rd_cnt;
    mark = op_log.size();
    req(0, 16'h0200, rand_line(), lat);
    req(0, 16'h0210, rand_line(), lat);
    req(1, 16'h0100, '0, lat);
    chk("miss_lat", lat, 3);
    chk("miss_first_op_read", op_log.size() > mark ? op_log[mark] : 1'b0, 1);
    chk("miss_one_read", rd_cnt - r0, 1);
    wait_idle();
    chk("miss_then_drains", wr_cnt - w0, 2);

    // randomized traffic over a small address pool
    dmax = 3;
    for (int n = 0; n < 250; n++) begin
      req(1'($urandom_range(1, 0)), 16'h0400 + 16'($urandom_range(7, 0) * 16), rand_line(), lat);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_idle();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
